i2c_target_port: RTL and testbench
==================================

I2C_TARGET_PORT -- requirements
Module: i2c_target_port

Interface
REQ-001 Parameter DEVICE_ADR, default 7'b1110000, 7-bit target address that the block answers to.
REQ-002 Parameter FILT_LEN, default 3, the number of consecutive equal samples needed to accept a new SCL/SDA level.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 scl_i  input  1  raw bus SCL, asynchronous to clk.
REQ-006 sda_i  input  1  raw bus SDA, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release SDA.
REQ-008 reg_addr  output  8  register pointer for the current access.
REQ-009 reg_wdata  output  8  write data, valid while reg_we=1.
REQ-010 reg_we  output  1  one-clk write strobe.
REQ-011 reg_re  output  1  one-clk read request.
REQ-012 reg_rdata  input  8  read data, sampled exactly 2 clk after reg_re.
REQ-013 busy  output  1  high from an addressed START until STOP or until the block leaves the transaction.

Function
REQ-014 scl_i and sda_i shall pass through a 2-flop synchronizer and then a FILT_LEN-sample glitch filter; the filtered signals are sda_f and scl_f.
REQ-015 START shall be detected as sda_f falling while scl_f=1; STOP as sda_f rising while scl_f=1; both are detected in any state.
REQ-016 Bits shall be sampled on the rising edge of scl_f, MSB first.
REQ-017 sda_oe shall change only on falling edges of scl_f, or at STOP/START/reset.
REQ-018 The states shall be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-019 IDLE to ADDR shall occur on START; a repeated START in any state also goes to ADDR and keeps reg_addr.
REQ-020 After 8 bits in ADDR: if the address matches DEVICE_ADR, go to ADDR_ACK and drive the ACK; if it does not match, go to IDLE with sda_oe=0.
REQ-021 From ADDR_ACK, R/W=0 shall go to PTR and R/W=1 shall go to RD_DATA.
REQ-022 PTR shall collect 8 bits, load reg_addr, then go to PTR_ACK (ACK), then WR_DATA.
REQ-023 WR_DATA shall collect 8 bits and pulse reg_we for one clk with the current reg_addr/reg_wdata, then go to WR_ACK (ACK).
REQ-024 After each write ACK, reg_addr shall increment modulo 256 (0xFF wraps to 0x00).
REQ-025 On entry to RD_DATA, reg_re shall pulse once.
REQ-026 reg_rdata shall be latched into the shift register 2 clk after reg_re, before the first SCL falling edge of the byte.
REQ-027 Read bits shall be driven on SCL falling edges; sda_oe=1 when the bit is 0.
REQ-028 After 8 read bits, go to RD_ACK with SDA released and sample the controller's ACK/NACK.
REQ-029 In RD_ACK, ACK(0) shall increment reg_addr and return to RD_DATA; NACK(1) shall go to IDLE.
REQ-030 STOP in any state shall go to IDLE, release SDA, clear busy, and generate no strobe for a partial byte.
REQ-031 There is no clock stretching; correct operation requires a clk frequency of at least 20x the SCL frequency.
REQ-032 General-call address 0x00 shall be NACKed.

Reset
REQ-033 While rst_n=0, the state shall be IDLE and the filters shall be preset to 1.
REQ-034 While rst_n=0: sda_oe=0, reg_addr=0x00, reg_wdata=0x00, reg_we=0, reg_re=0, busy=0.
REQ-035 Reset asserted mid-byte shall release SDA immediately.
REQ-036 After reset release, the block shall ignore the bus until the next START.

Structure
REQ-037 Shared package i2c_pkg shall hold the state enum type and the START/STOP/ACK constants; the future controller shall reuse it.
REQ-038 The synchronizer and filter shall be one sub-module, i2c_glitch_filter, instantiated twice.

Verification
REQ-039 Write test: START, 0xE0, 0x10, 0xA5, 0x5A, STOP -> three ACKs, reg_we at addr 0x10 data 0xA5, then at addr 0x11 data 0x5A.
REQ-040 Read test: START, 0xE0, 0x20, Sr, 0xE1; model returns 0x3C then 0xC3; controller ACKs then NACKs -> bytes 0x3C, 0xC3 on SDA; reg_re at addr 0x20 and 0x21; final state IDLE.
REQ-041 Address mismatch: START, 0xA0 -> sda_oe stays 0 for the whole frame; no strobes.
REQ-042 Wrap test: pointer 0xFF, write 0x11, 0x22 -> writes at addr 0xFF and 0x00.
REQ-043 Glitch test: 1-clk pulses on SCL during the data phase -> no bit slip; data unchanged.
REQ-044 Abort test: STOP after 4 data bits, and separately rst_n low mid-ACK -> no reg_we; sda_oe=0 within 1 clk of reset or within filter latency of STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus conditions, ACK levels.
package i2c_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ADDR     = 4'd1;
    localparam state_t ST_ADDR_ACK = 4'd2;
    localparam state_t ST_PTR      = 4'd3;
    localparam state_t ST_PTR_ACK  = 4'd4;
    localparam state_t ST_WR_DATA  = 4'd5;
    localparam state_t ST_WR_ACK   = 4'd6;
    localparam state_t ST_RD_DATA  = 4'd7;
    localparam state_t ST_RD_ACK   = 4'd8;

    // Bus conditions seen on the filtered lines
    typedef enum logic [1:0] {
        COND_NONE  = 2'd0,
        COND_START = 2'd1,
        COND_STOP  = 2'd2
    } bus_cond_t;

    // SDA level during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Address byte matches the device; the general-call address never matches
    function automatic logic addr_match(input logic [7:0] adr_byte, input logic [6:0] dev);
        return (adr_byte[7:1] == dev) && (adr_byte[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer followed by a FILT_LEN-sample majority-free glitch filter.
// The output only moves once FILT_LEN consecutive synchronized samples agree.
module i2c_glitch_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] hist;

    // Synchronize, collect sample history, and accept a level only when stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            hist <= '1;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            hist <= FILT_LEN'({hist, sync[1]});
            if (&hist) begin
                dout <= 1'b1;
            end else if (~|hist) begin
                dout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_target_port.sv
// I2C target with an 8-bit register pointer and auto-incrementing
// register read/write strobes. No clock stretching.
module i2c_target_port
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADR = 7'b1110000,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_f, sda_f;
    logic scl_q, sda_q;
    logic scl_rise, scl_fall;
    bus_cond_t cond;

    state_t                state, state_n;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0]     shreg, shreg_n;
    logic [BYTE_W-1:0]     rx_byte;
    logic                  rw, rw_n;
    logic                  rd_dly;
    logic                  sda_oe_n, we_n, re_n, busy_n;
    logic [7:0]            addr_n, wdata_n;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scl_i),
        .dout  (scl_f)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sda_i),
        .dout  (sda_f)
    );

    // Previous filtered levels for edge and condition detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
            rd_dly <= 1'b0;
        end else begin
            scl_q  <= scl_f;
            sda_q  <= sda_f;
            rd_dly <= reg_re;
        end
    end

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign rx_byte  = {shreg[6:0], sda_f};

    // START / STOP only while SCL has been stably high
    always_comb begin
        cond = COND_NONE;
        if (scl_f && scl_q && sda_q && !sda_f) begin
            cond = COND_START;
        end else if (scl_f && scl_q && !sda_q && sda_f) begin
            cond = COND_STOP;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rw        <= rw_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            busy      <= busy_n;
        end
    end

    // Next-state and output logic; SDA only moves on SCL falling edges
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rw_n      = rw;
        sda_oe_n  = sda_oe;
        addr_n    = reg_addr;
        wdata_n   = reg_wdata;
        busy_n    = busy;
        we_n      = 1'b0;
        re_n      = 1'b0;

        // Read data arrives two clocks after the read request
        if (rd_dly) begin
            shreg_n = reg_rdata;
        end

        if (cond == COND_STOP) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
        end else if (cond == COND_START) begin
            state_n   = ST_ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match(rx_byte, DEVICE_ADR)) begin
                                state_n = ST_ADDR_ACK;
                                rw_n    = rx_byte[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = ~ACK;
                    end
                    if (scl_rise) begin
                        bit_cnt_n = '0;
                        if (state == ST_ADDR_ACK) begin
                            if (rw) begin
                                state_n = ST_RD_DATA;
                                re_n    = 1'b1;
                            end else begin
                                state_n = ST_PTR;
                            end
                        end else if (state == ST_WR_ACK) begin
                            state_n = ST_WR_DATA;
                            addr_n  = reg_addr + 8'd1;
                        end else begin
                            state_n = ST_WR_DATA;
                        end
                    end
                end
                ST_PTR, ST_WR_DATA: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_PTR) begin
                                addr_n  = rx_byte;
                                state_n = ST_PTR_ACK;
                            end else begin
                                wdata_n = rx_byte;
                                we_n    = 1'b1;
                                state_n = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        sda_oe_n = ~shreg[7];
                        shreg_n  = {shreg[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                    end
                    if (scl_rise) begin
                        bit_cnt_n = '0;
                        if (sda_f == ACK) begin
                            state_n = ST_RD_DATA;
                            addr_n  = reg_addr + 8'd1;
                            re_n    = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_port.sv
// Directed bench for i2c_target_port: bit-banged controller on an
// open-drain SDA wire, register read model, and strobe monitor.
module tb_i2c_target_port;

    localparam int unsigned Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_ctl;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];
    int         oe_cnt = 0;

    logic       re_q = 1'b0;
    logic [7:0] rd_addr_q = 8'h00;

    always #5 clk = ~clk;

    assign sda_bus = sda_ctl & ~sda_oe;

    i2c_target_port #(
        .DEVICE_ADR (7'b1110000),
        .FILT_LEN   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        case (a)
            8'h20:   return 8'h3C;
            8'h21:   return 8'hC3;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    // Register file read model: data valid only in the sampling cycle
    always @(posedge clk) begin
        re_q <= reg_re;
        if (reg_re) rd_addr_q <= reg_addr;
    end
    assign reg_rdata = re_q ? rd_model(rd_addr_q) : 8'h00;

    // Strobe and SDA-drive monitor
    always @(negedge clk) begin
        if (rst_n && reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (rst_n && reg_re) re_addr_q.push_back(reg_addr);
        if (sda_oe) oe_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic o);
        sda_ctl = b; clks(Q);
        scl = 1'b1; clks(Q);
        o = sda_bus; clks(Q);
        scl = 1'b0; clks(Q);
    endtask

    // Same bit with 1-clk SCL spikes in both the low and the high phase
    task automatic xfer_bit_g(input logic b, output logic o);
        sda_ctl = b; clks(3);
        scl = 1'b1; clks(1);
        scl = 1'b0; clks(Q - 4);
        scl = 1'b1; clks(3);
        scl = 1'b0; clks(1);
        scl = 1'b1; clks(Q - 4);
        o = sda_bus; clks(Q);
        scl = 1'b0; clks(Q);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; clks(Q);
        scl = 1'b1; clks(Q);
        sda_ctl = 1'b0; clks(Q);
        scl = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; clks(Q);
        scl = 1'b1; clks(Q);
        sda_ctl = 1'b1; clks(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            if (glitch) xfer_bit_g(d[i], o);
            else        xfer_bit(d[i], o);
        end
        xfer_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_in, output logic [7:0] d);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, o);
            d[i] = o;
        end
        xfer_bit(ack_in, o);
    endtask

    initial begin
        logic       ack;
        logic       o;
        logic [7:0] d;
        int         wb, rb, ob;

        rst_n   = 1'b0;
        scl     = 1'b1;
        sda_ctl = 1'b1;
        clks(5);

        // Reset values
        chk("rst_sda_oe", 32'(sda_oe), 32'h0);
        chk("rst_reg_addr", 32'(reg_addr), 32'h00);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
        chk("rst_reg_we", 32'(reg_we), 32'h0);
        chk("rst_reg_re", 32'(reg_re), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        clks(20);

        // Write: pointer 0x10, data 0xA5, 0x5A
        wb = we_addr_q.size();
        i2c_start();
        send_byte(8'hE0, 1'b0, ack); chk("wr_adr_ack", 32'(ack), 32'h0);
        chk("wr_busy", 32'(busy), 32'h1);
        send_byte(8'h10, 1'b0, ack); chk("wr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'hA5, 1'b0, ack); chk("wr_d0_ack", 32'(ack), 32'h0);
        send_byte(8'h5A, 1'b0, ack); chk("wr_d1_ack", 32'(ack), 32'h0);
        i2c_stop();
        clks(10);
        chk("wr_we_count", 32'(we_addr_q.size() - wb), 32'd2);
        chk("wr_we0_addr", 32'(we_addr_q[wb]), 32'h10);
        chk("wr_we0_data", 32'(we_data_q[wb]), 32'hA5);
        chk("wr_we1_addr", 32'(we_addr_q[wb + 1]), 32'h11);
        chk("wr_we1_data", 32'(we_data_q[wb + 1]), 32'h5A);
        chk("wr_addr_after", 32'(reg_addr), 32'h12);
        chk("wr_busy_after_stop", 32'(busy), 32'h0);

        // Read: pointer 0x20, repeated START, two bytes, ACK then NACK
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        i2c_start();
        send_byte(8'hE0, 1'b0, ack); chk("rd_adr_ack", 32'(ack), 32'h0);
        send_byte(8'h20, 1'b0, ack); chk("rd_ptr_ack", 32'(ack), 32'h0);
        i2c_start();
        send_byte(8'hE1, 1'b0, ack); chk("rd_adr2_ack", 32'(ack), 32'h0);
        recv_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'h3C);
        recv_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'hC3);
        clks(10);
        chk("rd_busy_after_nack", 32'(busy), 32'h0);
        chk("rd_sda_released", 32'(sda_oe), 32'h0);
        i2c_stop();
        clks(10);
        chk("rd_re_count", 32'(re_addr_q.size() - rb), 32'd2);
        chk("rd_re0_addr", 32'(re_addr_q[rb]), 32'h20);
        chk("rd_re1_addr", 32'(re_addr_q[rb + 1]), 32'h21);
        chk("rd_no_we", 32'(we_addr_q.size() - wb), 32'd0);
        chk("rd_addr_after", 32'(reg_addr), 32'h21);

        // Address mismatch and general call: never driven, no strobes
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        ob = oe_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack); chk("mis_nack", 32'(ack), 32'h1);
        send_byte(8'h55, 1'b0, ack); chk("mis_data_nack", 32'(ack), 32'h1);
        i2c_stop();
        i2c_start();
        send_byte(8'h00, 1'b0, ack); chk("gc_nack", 32'(ack), 32'h1);
        i2c_stop();
        clks(10);
        chk("mis_oe_never", 32'(oe_cnt - ob), 32'd0);
        chk("mis_no_we", 32'(we_addr_q.size() - wb), 32'd0);
        chk("mis_no_re", 32'(re_addr_q.size() - rb), 32'd0);
        chk("mis_busy", 32'(busy), 32'h0);

        // Pointer wrap at 0xFF
        wb = we_addr_q.size();
        i2c_start();
        send_byte(8'hE0, 1'b0, ack);
        send_byte(8'hFF, 1'b0, ack);
        send_byte(8'h11, 1'b0, ack);
        send_byte(8'h22, 1'b0, ack); chk("wrap_d1_ack", 32'(ack), 32'h0);
        i2c_stop();
        clks(10);
        chk("wrap_we_count", 32'(we_addr_q.size() - wb), 32'd2);
        chk("wrap_we0", 32'({we_addr_q[wb], we_data_q[wb]}), 32'hFF11);
        chk("wrap_we1", 32'({we_addr_q[wb + 1], we_data_q[wb + 1]}), 32'h0022);
        chk("wrap_addr_after", 32'(reg_addr), 32'h01);

        // SCL spikes during the data byte
        wb = we_addr_q.size();
        i2c_start();
        send_byte(8'hE0, 1'b0, ack);
        send_byte(8'h30, 1'b0, ack);
        send_byte(8'h96, 1'b1, ack); chk("glitch_ack", 32'(ack), 32'h0);
        i2c_stop();
        clks(10);
        chk("glitch_we_count", 32'(we_addr_q.size() - wb), 32'd1);
        chk("glitch_we0", 32'({we_addr_q[wb], we_data_q[wb]}), 32'h3096);

        // STOP after four data bits: no strobe
        wb = we_addr_q.size();
        i2c_start();
        send_byte(8'hE0, 1'b0, ack);
        send_byte(8'h40, 1'b0, ack);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, o);
        i2c_stop();
        clks(10);
        chk("abort_no_we", 32'(we_addr_q.size() - wb), 32'd0);
        chk("abort_sda_oe", 32'(sda_oe), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);

        // Reset asserted while the address ACK is being driven
        wb = we_addr_q.size();
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hE0;
            xfer_bit(d[i], o);
        end
        sda_ctl = 1'b1; clks(Q);
        scl = 1'b1; clks(Q);
        chk("rst_mid_ack_driven", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack_release", 32'(sda_oe), 32'h0);
        clks(1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_addr", 32'(reg_addr), 32'h00);
        scl = 1'b0; clks(Q);
        rst_n = 1'b1;
        clks(20);
        // Bus traffic without a START must be ignored
        send_byte(8'h77, 1'b0, ack); chk("post_rst_ignore", 32'(ack), 32'h1);
        i2c_stop();
        clks(10);
        chk("rst_mid_no_we", 32'(we_addr_q.size() - wb), 32'd0);

        // Normal operation resumes at the next START
        i2c_start();
        send_byte(8'hE0, 1'b0, ack); chk("recover_ack", 32'(ack), 32'h0);
        send_byte(8'h50, 1'b0, ack);
        send_byte(8'hAB, 1'b0, ack);
        i2c_stop();
        clks(10);
        chk("recover_we_count", 32'(we_addr_q.size() - wb), 32'd1);
        chk("recover_we0", 32'({we_addr_q[wb], we_data_q[wb]}), 32'h50AB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
